i2df_seq: RTL and testbench

- Parametrised, multi-cycle integer-to-decimal-float converter; successor to the fixed 96-bit converter.
- Converts an unsigned or signed IWID-bit integer to a BCD-coefficient decimal float of width FPWID.
- Binary-to-BCD conversion is iterative (double-dabble, one bit per cycle). Excess digits are then shifted out one digit per cycle, followed by directed rounding.
- Sits in the dfpu conversion path beside the other dfpu units and uses the same ld/done handshake.

---
 rtl/dfp_pkg.sv | 37 +++
 rtl/bcd_inc_n.sv | 32 +++
 rtl/i2df_seq.sv | 197 +++++++++++++++++++
 tb/tb_i2df_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dfp_pkg.sv
// Shared dfpu definitions: rounding-mode and converter state encodings, plus
// the format-constants helper that derives coefficient digits and exponent
// bias from the format width and exponent field width.
package dfp_pkg;

   typedef enum logic [2:0] {
      RM_HALF_EVEN = 3'd0,
      RM_ZERO      = 3'd1,
      RM_POS_INF   = 3'd2,
      RM_NEG_INF   = 3'd3,
      RM_HALF_AWAY = 3'd4
   } rm_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CONV  = 3'd1,
      ST_NORM  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_ROUND = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   typedef struct packed {
      int exw;
      int ndig;
      int bias;
   } fmt_t;

   function automatic fmt_t fmt_of(input int fpwid, input int exw);
      fmt_t f;
      f.exw  = exw;
      f.ndig = (fpwid - 1 - exw) / 4;
      f.bias = (1 << (exw - 1)) - 1;
      return f;
   endfunction

endpackage

// File: rtl/bcd_inc_n.sv
// Combinational NDIG-digit BCD incrementer.
//   a  : BCD operand, NDIG digits
//   y  : a + 1 in BCD (wraps to zero when a is all nines)
//   co : decimal carry out of the top digit
module bcd_inc_n #(
   parameter int NDIG = 20
)(
   input  logic [4*NDIG-1:0] a,
   output logic [4*NDIG-1:0] y,
   output logic              co
);

   logic       c;
   logic [3:0] d;

   always_comb begin
      c = 1'b1;
      d = 4'd0;
      y = '0;
      for (int n = 0; n < NDIG; n++) begin
         d = a[4*n +: 4];
         if (c && d == 4'd9) begin
            y[4*n +: 4] = 4'd0;
         end else begin
            y[4*n +: 4] = d + {3'b000, c};
            c = 1'b0;
         end
      end
      co = c;
   end

endmodule

// File: rtl/i2df_seq.sv
// Multi-cycle integer to BCD decimal-float converter.
//   clk, rst (sync, active-high), ce (global clock enable)
//   ld      : start/restart pulse, op selects signed input, rm rounding mode
//   i       : IWID-bit integer operand
//   o       : {sign, exponent, BCD coefficient}, held until the next ld
//   done    : result valid; busy : conversion in flight
//   inexact : nonzero digits were discarded by the last conversion
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for ld
// ST_CONV  | double-dabble, one magnitude bit per cycle
// ST_NORM  | count significant digits, load excess-digit count
// ST_SHIFT | drop one low digit per cycle into guard/sticky
// ST_ROUND | apply rounding, register result
// ST_DONE  | result held, waiting for ld
module i2df_seq
   import dfp_pkg::*;
#(
   parameter int FPWID = 96,
   parameter int EXW   = 15,
   parameter int IWID  = FPWID
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             ld,
   input  logic             op,
   input  logic [2:0]       rm,
   input  logic [IWID-1:0]  i,
   output logic [FPWID-1:0] o,
   output logic             done,
   output logic             busy,
   output logic             inexact
);

   localparam fmt_t FMT  = fmt_of(FPWID, EXW);
   localparam int   NDIG = FMT.ndig;
   localparam int   BIAS = FMT.bias;
   localparam int   IDIG = (IWID * 301) / 1000 + 1;
   // register is never narrower than the coefficient so small IWID still works
   localparam int   BDIG = (IDIG > NDIG) ? IDIG : NDIG;
   localparam int   CW   = $clog2(IWID + 1);
   localparam int   KW   = $clog2(BDIG + 1);

   state_t              state;
   logic                sign;
   logic [IWID-1:0]     mag;
   logic [4*BDIG-1:0]   bcd;
   logic [CW-1:0]       bit_cnt;
   logic [KW-1:0]       k_cnt;
   logic [EXW-1:0]      expo;
   logic [3:0]          guard;
   logic                sticky;

   logic                neg_in;
   logic [IWID-1:0]     mag_in;
   logic [4*BDIG-1:0]   bcd_adj;
   logic [KW-1:0]       nd;
   logic [KW-1:0]       k_norm;
   logic [4*NDIG-1:0]   coeff;
   logic [4*NDIG-1:0]   coeff_inc;
   logic                inc_co;
   logic                round_up;
   logic                g_nz;
   logic [4*NDIG-1:0]   coeff_rnd;
   logic [EXW-1:0]      exp_rnd;
   logic [FPWID-1:0]    o_nxt;

   // negating the most negative value yields 2^(IWID-1) as unsigned
   assign neg_in = op & i[IWID-1];
   assign mag_in = neg_in ? -i : i;

   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < BDIG; d++) begin
         if (bcd[4*d +: 4] >= 4'd5)
            bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
   end

   always_comb begin
      nd = KW'(1);
      for (int d = 0; d < BDIG; d++) begin
         if (bcd[4*d +: 4] != 4'd0)
            nd = KW'(d + 1);
      end
   end

   assign k_norm = (nd > KW'(NDIG)) ? nd - KW'(NDIG) : '0;

   assign coeff = bcd[4*NDIG-1:0];
   assign g_nz  = (guard != 4'd0);

   always_comb begin
      round_up = 1'b0;
      case (rm)
         RM_ZERO:      round_up = 1'b0;
         RM_POS_INF:   round_up = ~sign & (g_nz | sticky);
         RM_NEG_INF:   round_up = sign & (g_nz | sticky);
         RM_HALF_AWAY: round_up = (guard >= 4'd5);
         default:      round_up = (guard > 4'd5) |
                                  ((guard == 4'd5) & (sticky | bcd[0]));
      endcase
   end

   bcd_inc_n #(.NDIG(NDIG)) u_inc (
      .a  (coeff),
      .y  (coeff_inc),
      .co (inc_co)
   );

   // a carry out of the top digit means the coefficient hit 10^NDIG
   always_comb begin
      coeff_rnd = coeff;
      exp_rnd   = expo;
      if (round_up) begin
         if (inc_co) begin
            coeff_rnd = {4'd1, {(4*NDIG-4){1'b0}}};
            exp_rnd   = expo + EXW'(1);
         end else begin
            coeff_rnd = coeff_inc;
         end
      end
   end

   always_comb begin
      o_nxt                   = '0;
      o_nxt[FPWID-1]          = sign;
      o_nxt[FPWID-2 -: EXW]   = exp_rnd;
      o_nxt[4*NDIG-1:0]       = coeff_rnd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         o       <= '0;
         done    <= 1'b0;
         inexact <= 1'b0;
         sign    <= 1'b0;
         mag     <= '0;
         bcd     <= '0;
         bit_cnt <= '0;
         k_cnt   <= '0;
         expo    <= '0;
         guard   <= '0;
         sticky  <= 1'b0;
      end else if (ce) begin
         if (ld) begin
            sign    <= neg_in;
            mag     <= mag_in;
            bcd     <= '0;
            bit_cnt <= CW'(IWID);
            done    <= 1'b0;
            inexact <= 1'b0;
            state   <= ST_CONV;
         end else begin
            case (state)
               ST_CONV: begin
                  bcd     <= {bcd_adj[4*BDIG-2:0], mag[IWID-1]};
                  mag     <= mag << 1;
                  bit_cnt <= bit_cnt - CW'(1);
                  if (bit_cnt == CW'(1))
                     state <= ST_NORM;
               end
               ST_NORM: begin
                  k_cnt  <= k_norm;
                  expo   <= EXW'(BIAS);
                  guard  <= '0;
                  sticky <= 1'b0;
                  state  <= (k_norm != '0) ? ST_SHIFT : ST_ROUND;
               end
               ST_SHIFT: begin
                  sticky <= sticky | g_nz;
                  guard  <= bcd[3:0];
                  bcd    <= bcd >> 4;
                  expo   <= expo + EXW'(1);
                  k_cnt  <= k_cnt - KW'(1);
                  if (k_cnt == KW'(1))
                     state <= ST_ROUND;
               end
               ST_ROUND: begin
                  o       <= o_nxt;
                  inexact <= g_nz | sticky;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
               default: ;
            endcase
         end
      end
   end

   assign busy = (state == ST_CONV) || (state == ST_NORM) ||
                 (state == ST_SHIFT) || (state == ST_ROUND);

endmodule

// File: tb/tb_i2df_seq.sv
// Bench for i2df_seq at FPWID=IWID=96, EXW=15: directed vectors with literal
// expectations, and a decimal-arithmetic reference model checked every cycle.
module tb_i2df_seq;

   localparam int FPWID = 96;
   localparam int EXW   = 15;
   localparam int IWID  = 96;

   logic             clk = 1'b0;
   logic             rst, ce, ld, op;
   logic [2:0]       rm;
   logic [IWID-1:0]  i;
   logic [FPWID-1:0] o;
   logic             done, busy, inexact;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   i2df_seq #(.FPWID(FPWID), .EXW(EXW), .IWID(IWID)) dut (
      .clk(clk), .rst(rst), .ce(ce), .ld(ld), .op(op), .rm(rm), .i(i),
      .o(o), .done(done), .busy(busy), .inexact(inexact)
   );

   typedef struct packed {
      logic [95:0] o;
      logic        inex;
      int          lat;
   } res_t;

   function automatic logic [127:0] pow10(input int n);
      logic [127:0] p;
      p = 128'd1;
      for (int j = 0; j < n; j++) p = p * 10;
      return p;
   endfunction

   // value-level reference: digits via division, rounding on integers
   function automatic res_t ref_conv(input logic op_v, input logic [2:0] rm_v,
                                     input logic [95:0] i_v);
      res_t         r;
      logic         neg, st, up;
      logic [127:0] mag, t, p, q, rem, h;
      logic [3:0]   g;
      logic [79:0]  cf;
      int           nd, k, e;
      neg = op_v & i_v[95];
      mag = {32'd0, neg ? (~i_v + 96'd1) : i_v};
      nd = 0;
      t = mag;
      do begin nd++; t = t / 10; end while (t != 0);
      k = (nd > 20) ? nd - 20 : 0;
      p = pow10(k);
      q = mag / p;
      rem = mag % p;
      if (k > 0) begin
         h  = p / 10;
         g  = 4'(rem / h);
         st = (rem % h) != 0;
      end else begin
         g  = 4'd0;
         st = 1'b0;
      end
      case (rm_v)
         3'd1:    up = 1'b0;
         3'd2:    up = !neg && (g != 0 || st);
         3'd3:    up = neg && (g != 0 || st);
         3'd4:    up = (g >= 5);
         default: up = (g > 5) || (g == 5 && (st || q[0]));
      endcase
      e = 16383 + k;
      if (up) q = q + 1;
      if (q == pow10(20)) begin q = pow10(19); e++; end
      for (int d = 0; d < 20; d++) begin
         cf[4*d +: 4] = 4'(q % 10);
         q = q / 10;
      end
      r.o    = {neg, 15'(e), cf};
      r.inex = (g != 0) || st;
      r.lat  = IWID + k + 2;
      return r;
   endfunction

   res_t        pend  = '0;
   logic [95:0] m_o   = '0;
   logic        m_done = 1'b0, m_busy = 1'b0, m_inex = 1'b0;
   int          m_el  = 0;
   logic        chk_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_o <= '0; m_done <= 1'b0; m_busy <= 1'b0; m_inex <= 1'b0; m_el <= 0;
      end else if (ce) begin
         if (ld) begin
            pend   <= ref_conv(op, rm, i);
            m_el   <= 0;
            m_busy <= 1'b1;
            m_done <= 1'b0;
         end else if (m_busy) begin
            m_el <= m_el + 1;
            if (m_el + 1 == pend.lat) begin
               m_o    <= pend.o;
               m_inex <= pend.inex;
               m_done <= 1'b1;
               m_busy <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if (o !== m_o || done !== m_done || busy !== m_busy ||
             (m_done && inexact !== m_inex)) begin
            n_bad++;
            $display("FAIL cycle t=%0t o=%h want %h done=%b want %b busy=%b want %b inexact=%b want %b",
                     $time, o, m_o, done, m_done, busy, m_busy, inexact, m_inex);
         end
      end
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic start(input logic op_v, input logic [2:0] rm_v, input logic [95:0] i_v);
      @(negedge clk);
      ld = 1'b1; op = op_v; rm = rm_v; i = i_v;
      @(negedge clk);
      ld = 1'b0;
   endtask

   // counts clock edges after the ld edge until done; -1 on timeout
   task automatic wait_done(input int ce_off_at, output int lat);
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (done) begin lat = n; break; end
         if (ce_off_at > 0 && n == ce_off_at) ce = 1'b0;
         if (ce_off_at > 0 && n == ce_off_at + 10) ce = 1'b1;
      end
   endtask

   task automatic run_vec(input string nm, input logic op_v, input logic [2:0] rm_v,
                          input logic [95:0] i_v, input logic [95:0] want_o,
                          input logic want_inex, input int want_lat);
      int lat;
      start(op_v, rm_v, i_v);
      wait_done(0, lat);
      chk({nm, " latency"}, 128'(lat), 128'(want_lat));
      chk({nm, " o"}, {32'd0, o}, {32'd0, want_o});
      chk({nm, " inexact"}, {127'd0, inexact}, {127'd0, want_inex});
   endtask

   initial begin
      int lat;
      rst = 1'b1; ce = 1'b1; ld = 1'b0; op = 1'b0; rm = 3'd0; i = '0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset o", {32'd0, o}, 128'd0);
      chk("reset done", {127'd0, done}, 128'd0);
      chk("reset busy", {127'd0, busy}, 128'd0);
      chk("reset inexact", {127'd0, inexact}, 128'd0);
      rst = 1'b0;

      run_vec("u one", 0, 0, 96'd1, 96'h3FFF_0000_0000_0000_0000_0001, 0, 98);
      run_vec("s minus one", 1, 0, '1, 96'hBFFF_0000_0000_0000_0000_0001, 0, 98);
      run_vec("u 12345678", 0, 0, 96'd12345678, 96'h3FFF_0000_0000_0000_1234_5678, 0, 98);
      run_vec("s op positive", 1, 0, 96'd12345678, 96'h3FFF_0000_0000_0000_1234_5678, 0, 98);
      run_vec("u zero", 0, 0, 96'd0, 96'h3FFF_0000_0000_0000_0000_0000, 0, 98);
      run_vec("u 1e20", 0, 0, 96'd100000000000000000000,
              96'h4000_1000_0000_0000_0000_0000, 0, 99);
      run_vec("u 21dig rm0", 0, 0, 96'd123456789012345678901,
              96'h4000_1234_5678_9012_3456_7890, 1, 99);
      run_vec("u 21dig rm2", 0, 2, 96'd123456789012345678901,
              96'h4000_1234_5678_9012_3456_7891, 1, 99);
      run_vec("u 21dig rm1", 0, 1, 96'd123456789012345678901,
              96'h4000_1234_5678_9012_3456_7890, 1, 99);
      run_vec("s neg rm3", 1, 3, -96'd123456789012345678901,
              96'hC000_1234_5678_9012_3456_7891, 1, 99);
      run_vec("s neg rm2", 1, 2, -96'd123456789012345678901,
              96'hC000_1234_5678_9012_3456_7890, 1, 99);
      run_vec("carry rm0", 0, 0, 96'd999999999999999999995,
              96'h4001_1000_0000_0000_0000_0000, 1, 99);
      run_vec("carry rm1", 0, 1, 96'd999999999999999999995,
              96'h4000_9999_9999_9999_9999_9999, 1, 99);
      run_vec("carry rm4", 0, 4, 96'd999999999999999999995,
              96'h4001_1000_0000_0000_0000_0000, 1, 99);
      run_vec("carry rm7", 0, 7, 96'd999999999999999999995,
              96'h4001_1000_0000_0000_0000_0000, 1, 99);
      run_vec("tie even rm0", 0, 0, 96'd123456789012345678905,
              96'h4000_1234_5678_9012_3456_7890, 1, 99);
      run_vec("tie even rm4", 0, 4, 96'd123456789012345678905,
              96'h4000_1234_5678_9012_3456_7891, 1, 99);
      run_vec("sticky k2", 0, 0, 96'd1234567890123456789051,
              96'h4001_1234_5678_9012_3456_7891, 1, 100);
      run_vec("most negative", 1, 0, 96'h8000_0000_0000_0000_0000_0000,
              96'hC008_3961_4081_2571_3216_8797, 1, 107);
      run_vec("u all ones", 0, 0, '1, 96'h4008_7922_8162_5142_6433_7594, 1, 107);

      // restart mid-conversion
      start(0, 0, 96'd12345678);
      repeat (39) @(negedge clk);
      chk("restart done low", {127'd0, done}, 128'd0);
      run_vec("restart second", 0, 0, 96'd1, 96'h3FFF_0000_0000_0000_0000_0001, 0, 98);

      // clock enable held low for ten cycles
      start(0, 0, 96'd12345678);
      wait_done(30, lat);
      chk("ce stall latency", 128'(lat), 128'd108);
      chk("ce stall o", {32'd0, o}, {32'd0, 96'h3FFF_0000_0000_0000_1234_5678});

      // synchronous reset mid-conversion
      start(0, 0, 96'd123456789012345678901);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort o", {32'd0, o}, 128'd0);
      chk("abort done", {127'd0, done}, 128'd0);
      chk("abort busy", {127'd0, busy}, 128'd0);
      repeat (5) @(negedge clk);
      chk("abort idle done", {127'd0, done}, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
